// File: rtl/debug_pkg.sv
// Shared timing defaults for the LED debug viewer; board tops use these,
// benches override them with small values.
package debug_pkg;

  localparam int unsigned REFRESH_CYCLES_DEFAULT  = 67108864;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Counter/select width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer and one-cycle press pulse
// for a single raw mechanical button.
module btn_debounce
  import debug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      // Rising edge of the debounced level only; releases never pulse.
      r_press    <= r_stable & ~r_stable_q;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_debug_display.sv
// Board debug viewer: shows an LED_W-bit window of one of NUM_CH debug words,
// refreshed periodically, with debounced channel/window select buttons.
module led_debug_display
  import debug_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned LED_W           = 16,
  parameter int unsigned REFRESH_CYCLES  = REFRESH_CYCLES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CH*DATA_W-1:0]                 ch_data,
  input  logic                                     btn_next,
  input  logic                                     btn_win,
  input  logic                                     hold,
  output logic [LED_W-1:0]                         led,
  output logic [$clog2(NUM_CH)-1:0]                ch_sel,
  output logic [clog2_min1(DATA_W/LED_W)-1:0]      win_sel,
  output logic                                     refresh_tick
);

  localparam int unsigned NUM_WIN = DATA_W / LED_W;
  localparam int unsigned CH_W    = $clog2(NUM_CH);
  localparam int unsigned WIN_W   = clog2_min1(NUM_WIN);
  localparam int unsigned RC_W    = clog2_min1(REFRESH_CYCLES);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NUM_WIN - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_CYCLES - 1);

  logic [CH_W-1:0]   r_ch_sel;
  logic [WIN_W-1:0]  r_win_sel;
  logic              r_sel_changed;
  logic [RC_W-1:0]   r_refresh_cnt;
  logic [LED_W-1:0]  r_led;

  logic              w_press_next;
  logic              w_press_win;
  logic              w_tick;
  logic              w_load;
  logic [DATA_W-1:0] w_chan;
  logic [LED_W-1:0]  w_window;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_next),
    .o_press (w_press_next)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_win (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_win),
    .o_press (w_press_win)
  );

  always_comb begin
    w_chan = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (r_ch_sel == CH_W'(k)) w_chan = ch_data[k*DATA_W +: DATA_W];
    end
    w_window = '0;
    for (int unsigned w = 0; w < NUM_WIN; w++) begin
      if (r_win_sel == WIN_W'(w)) w_window = w_chan[w*LED_W +: LED_W];
    end
  end

  assign w_tick = (r_refresh_cnt == RC_LAST);
  // A selection change always loads, even under hold; a tick loads only when not held.
  assign w_load = r_sel_changed | (w_tick & ~hold);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_sel      <= '0;
      r_win_sel     <= WIN_LAST;
      r_sel_changed <= 1'b0;
      r_refresh_cnt <= '0;
      r_led         <= '0;
    end else begin
      if (w_press_next) r_ch_sel <= (r_ch_sel == CH_LAST) ? '0 : r_ch_sel + 1'b1;
      if (w_press_win)  r_win_sel <= (r_win_sel == '0) ? WIN_LAST : r_win_sel - 1'b1;
      r_sel_changed <= w_press_next | w_press_win;
      r_refresh_cnt <= (r_sel_changed | w_tick) ? '0 : r_refresh_cnt + 1'b1;
      if (w_load) r_led <= w_window;
    end
  end

  assign led          = r_led;
  assign ch_sel       = r_ch_sel;
  assign win_sel      = r_win_sel;
  assign refresh_tick = w_tick;

endmodule

// File: doc/led_debug_display.md
Name: led_debug_display

Overview:
Parametrised board-level debug viewer. It samples one of NUM_CH debug words (for example the cycle counter, PC or register taps from the CPU) at a human-visible refresh rate and shows an LED_W-bit window of that word on the board LEDs. Two debounced buttons are used for control: one cycles through the channels, the other cycles through the windows. A hold input freezes the periodic refresh. It sits in the board top between the core and the LED pins.

Parameters:
- NUM_CH, 4: number of debug channels; must be at least 2.
- DATA_W, 32: width of each channel; must be a multiple of LED_W.
- LED_W, 16: number of LEDs driven.
- REFRESH_CYCLES, 67108864: clock cycles per periodic LED update; must be at least 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a button change is accepted; must be at least 1.

Ports:
- clk, in, 1: system clock. This is the only clock.
- reset, in, 1: synchronous, active-high reset.
- ch_data, in, NUM_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- btn_next, in, 1: raw asynchronous button; advances the channel.
- btn_win, in, 1: raw asynchronous button; advances the window.
- hold, in, 1: synchronous level input; high freezes periodic updates.
- led, out, LED_W: registered LED value.
- ch_sel, out, $clog2(NUM_CH): currently selected channel.
- win_sel, out, $clog2(DATA_W/LED_W) (minimum 1 bit): currently selected window.
- refresh_tick, out, 1: high on the cycle in which the refresh counter equals REFRESH_CYCLES-1.

Behaviour:
- Define NUM_WIN = DATA_W/LED_W. Window w is bits [w*LED_W +: LED_W] of the selected channel.
- Reset values: led=0, ch_sel=0, win_sel=NUM_WIN-1 (most significant window), refresh counter=0, synchronizer and debouncer state=0, press pulses=0. Reset held mid-debounce or mid-refresh discards all progress.
- Synchronizer: each button passes through two flops before the debouncer.
- Debouncer (per button):
  - Keeps a stable bit and a counter.
  - If sync==stable, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while sync!=stable: stable<=sync, counter<=0.
  - A registered one-cycle press pulse fires on the cycle after stable goes 0->1. Release (1->0) produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
- Selection:
  - A next pulse makes ch_sel increment on the following edge, wrapping NUM_CH-1 -> 0.
  - A win pulse makes win_sel decrement, wrapping 0 -> NUM_WIN-1. The order is therefore upper window first.
  - Pulses on both buttons in the same cycle apply both updates in that cycle.
- Selection change: the cycle after any pulse sets sel_changed. On that edge:
  - led loads the newly selected window.
  - The refresh counter clears to 0.
  - This happens regardless of hold.
- Periodic refresh:
  - The counter runs 0..REFRESH_CYCLES-1 and wraps.
  - refresh_tick is high while counter==REFRESH_CYCLES-1.
  - On that edge, if hold==0, led loads the selected window of the current ch_data.
  - If hold==1, led keeps its value. The counter keeps running.
- When sel_changed and refresh_tick coincide, a single load occurs and the counter goes to 0.
- led changes only on a load edge and never glitches in between.
- ch_data is sampled on the load edge only; no capture register is required.

Decomposition:
- Shared debug_pkg header: default timing constants (REFRESH_CYCLES_DEFAULT, DEBOUNCE_CYCLES_DEFAULT) so board tops and benches agree. Benches override them with small values.
- Sub-module btn_debounce (synchronizer + debouncer + press pulse), parameter DEBOUNCE_CYCLES, instantiated once per button.
- Window/channel selection and the refresh counter stay in led_debug_display.

Test Plan:
All scenarios use NUM_CH=4, DATA_W=32, LED_W=16, REFRESH_CYCLES=8, DEBOUNCE_CYCLES=4, with ch0=0xAAAA5555, ch1=0x12345678, ch2=0xDEADBEEF, ch3=0x0000FFFF.
1. Reset check: assert reset for 3 cycles, then release. Expect led=0, ch_sel=0, win_sel=1. At counter 7, refresh_tick=1. The next cycle led=0xAAAA, and refresh_tick repeats every 8 cycles.
2. Channel cycling: hold btn_next high for 10 cycles, then low. Expect exactly one ch_sel step to 1 and led=0x1234 one cycle later. Repeat 3 more presses and expect ch_sel 2, 3, 0; led 0xDEAD, 0x0000, 0xAAAA.
3. Window toggle: select ch2 and press btn_win. Expect win_sel=0 and led=0xBEEF. Press again and expect win_sel=1, led=0xDEAD.
4. Debounce rejection: pulse btn_next high for 3 cycles, then low; then toggle it every 2 cycles for 20 cycles. Expect ch_sel unchanged and no led load except periodic refreshes.
5. Hold: set hold=1, then change ch0 to 0x11112222. Across 3 refresh periods led stays 0xAAAA. Pressing btn_win gives led=0x2222 despite hold. After hold=0, the next tick gives led=0x2222.
6. Simultaneous and mid-operation reset: make both buttons' pulses land in the same cycle and expect ch_sel+1, win_sel-1, a single load, and the counter at 0. Then assert reset mid-debounce (btn held 2 cycles) and expect no pulse after release, with all outputs back at reset values.
